// File: rtl/fb_video_timing.sv
// fb_video_timing: raster timing generator and registered pixel output stage.
// Waits for a settled PLL lock, then scans H_TOTAL x V_TOTAL frames, pulls
// pixels from the line FIFO during the active window and drives RGB/DE/HS/VS.
// Any lock loss drops straight back to IDLE with outputs forced inactive.
module fb_video_timing #(
  parameter int H_ACTIVE    = 1600,
  parameter int H_FP        = 64,
  parameter int H_SYNC      = 192,
  parameter int H_BP        = 304,
  parameter int V_ACTIVE    = 1200,
  parameter int V_FP        = 1,
  parameter int V_SYNC      = 3,
  parameter int V_BP        = 46,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1,
  parameter int LOCK_SETTLE = 1024,
  parameter int PIX_W       = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] vid_rgb,
  output logic             vid_de,
  output logic             vid_hs,
  output logic             vid_vs,
  output logic             frame_start,
  output logic             running,
  output logic [15:0]      underflow_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare bit of headroom so region end points never wrap.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int SW = $clog2(LOCK_SETTLE + 1);

  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            lk_meta, lk;
  logic [SW-1:0]   settle_cnt;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            run_ok, active, hs_region, vs_region;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk      <= lk_meta;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: lock must hold for LOCK_SETTLE cycles; any drop returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (lk) state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (!lk)                           state_nxt = ST_IDLE;
        else if (settle_cnt == SETTLE_LAST) state_nxt = ST_RUN;
      end
      ST_RUN:    if (!lk) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: a RUN cycle with lock lost already counts as inactive, so
  // no pixel is consumed that could not be shown and outputs idle on the
  // same edge the FSM leaves RUN.
  always_comb begin
    run_ok    = (state == ST_RUN) && lk;
    active    = run_ok && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hs_region = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    vs_region = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    pix_ready = active;
  end

  // Settle counter: counts locked cycles inside SETTLE, cleared otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      settle_cnt <= '0;
    else if (state == ST_SETTLE && lk) settle_cnt <= settle_cnt + SW'(1);
    else                               settle_cnt <= '0;
  end

  // Raster counters: advance only in a locked RUN cycle, else park at origin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (run_ok) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end else begin
      h_cnt <= '0;
      v_cnt <= '0;
    end
  end

  // Registered video outputs, one cycle behind the counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_rgb     <= '0;
      vid_de      <= 1'b0;
      vid_hs      <= ~HS_POL;
      vid_vs      <= ~VS_POL;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      vid_rgb     <= (active && pix_valid) ? pix_data : '0;
      vid_de      <= active;
      vid_hs      <= (run_ok && hs_region) ? HS_POL : ~HS_POL;
      vid_vs      <= (run_ok && vs_region) ? VS_POL : ~VS_POL;
      frame_start <= active && (h_cnt == '0) && (v_cnt == '0);
      running     <= (state_nxt == ST_RUN);
    end
  end

  // Underflow counter: saturating, survives lock loss, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      underflow_cnt <= '0;
    else if (active && !pix_valid && (underflow_cnt != 16'hFFFF))
      underflow_cnt <= underflow_cnt + 16'd1;
  end

endmodule

// File: tb/tb_fb_video_timing.sv
// tb_fb_video_timing: randomized bench with a frame-position reference model.
// The model derives raster position from how long the synchronized lock has
// been continuously high, and predicts every registered output per cycle.
module tb_fb_video_timing;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int LS = 4, PW = 24;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic [PW-1:0] pix_data = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [PW-1:0] vid_rgb;
  logic          vid_de, vid_hs, vid_vs, frame_start, running;
  logic [15:0]   underflow_cnt;

  fb_video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_SETTLE(LS), .PIX_W(PW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .vid_rgb(vid_rgb), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .frame_start(frame_start), .running(running),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: synchronizer copy, lock streak length, predicted outputs.
  int            hist;
  bit            m_d1, m_lk;
  logic [PW-1:0] e_rgb;
  bit            e_de, e_hs, e_vs, e_fs, e_run;
  logic [15:0]   e_uf;
  int            cyc = 0;

  // Hand-pinned frame shape checks, enabled only in uninterrupted runs.
  bit pin_en = 0;
  int last_fs, de_acc, vs_acc, hs_len, since_de;
  bit prev_hs;

  int  mp, mh, mv;
  bit  m_run, m_ok, m_de, m_hsr, m_vsr;

  // Compare on the falling edge, then predict the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      hist = 0; m_d1 = 0; m_lk = 0;
      e_rgb = '0; e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_run = 0; e_uf = '0;
    end
    chk("vid_de", vid_de, e_de);
    chk("vid_rgb", vid_rgb, e_rgb);
    chk("vid_hs", vid_hs, e_hs);
    chk("vid_vs", vid_vs, e_vs);
    chk("frame_start", frame_start, e_fs);
    chk("running", running, e_run);
    chk("underflow_cnt", underflow_cnt, e_uf);

    // RUN holds once lock has been high for LS+1 cycles; position = excess.
    m_run = reset_n && (hist >= LS + 1);
    m_ok  = m_run && m_lk;
    mp    = m_run ? hist - (LS + 1) : 0;
    mh    = mp % HT;
    mv    = (mp / HT) % VT;
    m_de  = m_ok && mh < HA && mv < VA;
    m_hsr = m_ok && mh >= HA + HF && mh < HA + HF + HS;
    m_vsr = m_ok && mv >= VA + VF && mv < VA + VF + VS;
    chk("pix_ready", pix_ready, m_de);

    if (reset_n) begin
      e_de  = m_de;
      e_rgb = (m_de && pix_valid) ? pix_data : '0;
      e_hs  = m_hsr;
      e_vs  = m_vsr;
      e_fs  = m_de && mh == 0 && mv == 0;
      if (m_de && !pix_valid && e_uf != 16'hFFFF) e_uf = e_uf + 16'd1;
      hist  = m_lk ? hist + 1 : 0;
      e_run = (hist >= LS + 1);
      m_lk  = m_d1;
      m_d1  = pll_locked;
    end

    if (!pin_en) begin
      last_fs = -1; de_acc = 0; vs_acc = 0; hs_len = 0; since_de = 1000; prev_hs = 0;
    end else begin
      if (frame_start) begin
        if (last_fs >= 0) begin
          chk("fs_period", cyc - last_fs, 98);
          chk("de_per_frame", de_acc, 32);
          chk("vs_per_frame", vs_acc, 14);
        end
        last_fs = cyc; de_acc = 0; vs_acc = 0;
      end
      if (vid_de) de_acc++;
      if (vid_vs) vs_acc++;
      if (vid_hs && !prev_hs && since_de < HT) chk("hs_gap_after_de", since_de, 2);
      if (!vid_hs && prev_hs) chk("hs_width", hs_len, 2);
      hs_len   = vid_hs ? hs_len + 1 : 0;
      since_de = vid_de ? 0 : since_de + 1;
      prev_hs  = vid_hs;
    end
  end

  bit inc_mode = 1;

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    logic acc;
    acc = pix_ready && pix_valid;
    @(posedge clk);
    #1;
    if (inc_mode) begin
      if (acc) pix_data = pix_data + 1'b1;
    end else begin
      pix_data = PW'($urandom);
    end
  endtask

  task automatic wait_ready(input string nm);
    int g;
    g = 0;
    while (!pix_ready && g < 200) begin step(); g++; end
    chk(nm, (g < 200), 1);
  endtask

  int n, got, guard, low_left;
  logic [15:0] uf_save;

  initial begin
    // Reset, then lock asserted at cycle 0 with a continuous pixel stream.
    repeat (3) step();
    reset_n = 1; pll_locked = 1; pix_valid = 1; inc_mode = 1; pin_en = 1;
    n = 0;
    while (!running && n < 20) begin step(); n++; end
    chk("lock_to_run_edges", n, 7);
    repeat (300) step();

    // Three starved active cycles: timing unchanged, underflow counted.
    got = 0; guard = 0;
    while (got < 3 && guard < 200) begin
      pix_valid = 0;
      if (pix_ready) got++;
      step(); guard++;
    end
    pix_valid = 1;
    chk("starve_wait", (guard < 200), 1);
    repeat (5) step();
    chk("underflow_after_starve", underflow_cnt, 3);
    repeat (200) step();

    // Lock dropped mid-line.
    pin_en = 0; inc_mode = 0;
    wait_ready("mid_line_wait");
    repeat (3) step();
    uf_save = underflow_cnt;
    pll_locked = 0;
    repeat (3) step();
    chk("loss_running", running, 0);
    chk("loss_de", vid_de, 0);
    chk("loss_hs", vid_hs, 0);
    chk("loss_vs", vid_vs, 0);
    chk("loss_ready", pix_ready, 0);
    chk("loss_uf_kept", underflow_cnt, uf_save);
    pll_locked = 1;
    repeat (120) step();

    // One-cycle lock glitch during SETTLE forces a full settle again.
    pll_locked = 0; repeat (5) step();
    pll_locked = 1; repeat (5) step();
    pll_locked = 0; step();
    pll_locked = 1; repeat (40) step();

    // Random data, validity and lock drops.
    low_left = 0;
    for (int i = 0; i < 1500; i++) begin
      pix_valid = ($urandom_range(3) != 0);
      if (low_left > 0) begin
        low_left--;
        pll_locked = (low_left == 0);
      end else if ($urandom_range(199) == 0) begin
        low_left = $urandom_range(8, 1);
        pll_locked = 0;
      end
      step();
    end
    pll_locked = 1; pix_valid = 0;
    repeat (60) step();

    // Asynchronous reset between edges, mid-frame.
    wait_ready("pre_reset_wait");
    #2 reset_n = 0;
    #1;
    chk("areset_de", vid_de, 0);
    chk("areset_rgb", vid_rgb, 0);
    chk("areset_hs", vid_hs, 0);
    chk("areset_vs", vid_vs, 0);
    chk("areset_fs", frame_start, 0);
    chk("areset_running", running, 0);
    chk("areset_uf", underflow_cnt, 0);
    chk("areset_ready", pix_ready, 0);
    repeat (2) step();
    reset_n = 1;
    repeat (80) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
